// File: rtl/pwm_fade_pkg.sv
// pwm_fade_pkg
//   Shared definitions for the PWM fade sequencer.
//   - state_t   : 3-bit FSM state; values are what state_o reports.
//   - DW_DEF    : default duty width (must match the PWM peripheral).
//   - TW_DEF    : default dwell/hold counter width.
package pwm_fade_pkg;

  localparam int DW_DEF = 8;
  localparam int TW_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RAMP_UP = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_RAMP_DN = 3'd3,
    ST_HOLD_LO = 3'd4
  } state_t;

endpackage

// File: rtl/pwm_fade_timer.sv
// pwm_fade_timer
//   TW-bit up-counter shared by the ramp and hold states.
//   Ports:
//     clk    in  1   system clock
//     rst_n  in  1   asynchronous active-low reset
//     clr    in  1   reload count to zero on the next edge
//     limit  in  TW  expiry value
//     expire out 1   combinational, count == limit
module pwm_fade_timer #(
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [TW-1:0] limit,
  output logic          expire
);

  logic [TW-1:0] count_r;

  // Count register: cleared on request, otherwise free-running up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + {{(TW-1){1'b0}}, 1'b1};
    end
  end

  assign expire = (count_r == limit);

endmodule

// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer
//   Autonomous breathing/fade engine driving the PWM duty-cycle register.
//   Ramps min->max, holds, ramps max->min, holds, then finishes (or loops).
//   Optional feature macro: PWM_FADE_LOOP_EN enables continuous mode via loop_i.
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     start_i, stop_i      one-cycle start / abort requests (stop wins)
//     loop_i               continuous mode (only with PWM_FADE_LOOP_EN)
//     min_duty_i/max_duty_i trough / peak duty, latched at start
//     step_i               duty increment per step (0 behaves as 1)
//     dwell_i / hold_i     cycles per step / at peak and trough, minus one
//     duty_o, busy_o       duty to the PWM, sequence in progress
//     done_o, err_o        completion pulse, rejected-start pulse
//     state_o              FSM state for debug
module pwm_fade_sequencer
  import pwm_fade_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          loop_i,
  input  logic [DW-1:0] min_duty_i,
  input  logic [DW-1:0] max_duty_i,
  input  logic [DW-1:0] step_i,
  input  logic [TW-1:0] dwell_i,
  input  logic [TW-1:0] hold_i,
  output logic [DW-1:0] duty_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [2:0]    state_o
);

  state_t          state_r, state_nxt_s;
  logic [DW-1:0]   duty_r, duty_nxt_s;
  logic            busy_r, done_r, done_nxt_s, err_r, err_nxt_s;
  logic            cfg_load_s, tmr_clr_s, expire_s, loop_en_s;
  logic [DW-1:0]   min_r, max_r, step_r;
  logic [TW-1:0]   dwell_r, hold_r, limit_s;
  logic [DW:0]     sum_s;
  logic signed [DW:0] diff_s;

`ifdef PWM_FADE_LOOP_EN
  assign loop_en_s = loop_i;
`else
  logic unused_loop_s;
  assign unused_loop_s = loop_i;
  assign loop_en_s     = 1'b0;
`endif

  // Hold states time against hold, ramp states against dwell.
  assign limit_s = ((state_r == ST_HOLD_HI) || (state_r == ST_HOLD_LO)) ? hold_r : dwell_r;

  pwm_fade_timer #(.TW(TW)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr_s),
    .limit  (limit_s),
    .expire (expire_s)
  );

  // One extra bit so the up-ramp can detect overflow past the DW range,
  // and sign on the down-ramp so an underflow compares below min.
  assign sum_s  = {1'b0, duty_r} + {1'b0, step_r};
  assign diff_s = $signed({1'b0, duty_r}) - $signed({1'b0, step_r});

  // Next-state, next-duty and pulse decode.
  always_comb begin
    state_nxt_s = state_r;
    duty_nxt_s  = duty_r;
    done_nxt_s  = 1'b0;
    err_nxt_s   = 1'b0;
    cfg_load_s  = 1'b0;
    tmr_clr_s   = 1'b0;
    if (stop_i && (state_r != ST_IDLE)) begin
      state_nxt_s = ST_IDLE;
      duty_nxt_s  = min_r;
      tmr_clr_s   = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tmr_clr_s = 1'b1;
          if (start_i && !stop_i) begin
            if (min_duty_i >= max_duty_i) begin
              err_nxt_s = 1'b1;
            end else begin
              cfg_load_s  = 1'b1;
              state_nxt_s = ST_RAMP_UP;
              duty_nxt_s  = min_duty_i;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RAMP_UP: begin
          tmr_clr_s = expire_s;
          if (expire_s) begin
            if (sum_s >= {1'b0, max_r}) begin
              duty_nxt_s  = max_r;
              state_nxt_s = ST_HOLD_HI;
            end else begin
              duty_nxt_s = sum_s[DW-1:0];
            end
          end else begin
            state_nxt_s = ST_RAMP_UP;
          end
        end
        ST_HOLD_HI: begin
          tmr_clr_s = expire_s;
          if (expire_s) begin
            state_nxt_s = ST_RAMP_DN;
          end else begin
            state_nxt_s = ST_HOLD_HI;
          end
        end
        ST_RAMP_DN: begin
          tmr_clr_s = expire_s;
          if (expire_s) begin
            if (diff_s <= $signed({1'b0, min_r})) begin
              duty_nxt_s  = min_r;
              state_nxt_s = ST_HOLD_LO;
            end else begin
              duty_nxt_s = diff_s[DW-1:0];
            end
          end else begin
            state_nxt_s = ST_RAMP_DN;
          end
        end
        ST_HOLD_LO: begin
          tmr_clr_s = expire_s;
          if (expire_s) begin
            done_nxt_s  = 1'b1;
            state_nxt_s = loop_en_s ? ST_RAMP_UP : ST_IDLE;
          end else begin
            state_nxt_s = ST_HOLD_LO;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          tmr_clr_s   = 1'b1;
        end
      endcase
    end
  end

  // FSM, duty and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      duty_r  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      duty_r  <= duty_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= done_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  // Configuration latch: captured only when a start is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_r   <= '0;
      max_r   <= '0;
      step_r  <= '0;
      dwell_r <= '0;
      hold_r  <= '0;
    end else if (cfg_load_s) begin
      min_r   <= min_duty_i;
      max_r   <= max_duty_i;
      step_r  <= (step_i == '0) ? {{(DW-1){1'b0}}, 1'b1} : step_i;
      dwell_r <= dwell_i;
      hold_r  <= hold_i;
    end else begin
      min_r   <= min_r;
    end
  end

  assign duty_o  = duty_r;
  assign busy_o  = busy_r;
  assign done_o  = done_r;
  assign err_o   = err_r;
  assign state_o = state_r;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Directed testbench for pwm_fade_sequencer (default DW=8, TW=16).
// Build with +define+PWM_FADE_LOOP_EN to exercise continuous mode.
module tb_pwm_fade_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start_i, stop_i, loop_i;
  logic [7:0]  min_duty_i, max_duty_i, step_i;
  logic [15:0] dwell_i, hold_i;
  logic [7:0]  duty_o;
  logic        busy_o, done_o, err_o;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_fade_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i), .loop_i(loop_i),
    .min_duty_i(min_duty_i), .max_duty_i(max_duty_i), .step_i(step_i),
    .dwell_i(dwell_i), .hold_i(hold_i), .duty_o(duty_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [7:0] mn, input logic [7:0] mx, input logic [7:0] st,
                     input logic [15:0] dw, input logic [15:0] hd);
    min_duty_i = mn; max_duty_i = mx; step_i = st; dwell_i = dw; hold_i = hd;
  endtask

  // Pulse start for one edge; returns positioned in cycle 1 of the run.
  task automatic go();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && state_o != 3'd0; k++) tick();
    chk("wait_idle", state_o, 3'd0);
  endtask

  logic [7:0] exp1 [9] = '{8'd0, 8'd4, 8'd8, 8'd8, 8'd8, 8'd4, 8'd0, 8'd0, 8'd0};
  logic [7:0] exp2 [7] = '{8'd10, 8'd210, 8'd255, 8'd255, 8'd55, 8'd10, 8'd10};
  logic [2:0] st2  [7] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd0};
  logic [7:0] exp6 [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd2, 8'd1, 8'd0};
  int done_cnt;
  int busy_drop;

  initial begin
    rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0; loop_i = 1'b0;
    cfg(8'd0, 8'd0, 8'd0, 16'd0, 16'd0);
    #12;
    chk("reset_duty", duty_o, 8'd0);
    chk("reset_state", state_o, 3'd0);
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_done", done_o, 1'b0);
    chk("reset_err", err_o, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1. basic sequence
    cfg(8'd0, 8'd8, 8'd4, 16'd0, 16'd1);
    go();
    chk("t1_state_c1", state_o, 3'd1);
    chk("t1_busy_c1", busy_o, 1'b1);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t1_duty_c%0d", i + 1), duty_o, exp1[i]);
      if (i < 8) tick();
    end
    chk("t1_state_c9", state_o, 3'd0);
    chk("t1_done_c9", done_o, 1'b1);
    chk("t1_busy_c9", busy_o, 1'b0);
    tick();
    chk("t1_done_c10", done_o, 1'b0);
    chk("t1_duty_idle", duty_o, 8'd0);

    // 2. saturation on both ramps
    cfg(8'd10, 8'd255, 8'd200, 16'd0, 16'd0);
    go();
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("t2_duty_c%0d", i + 1), duty_o, exp2[i]);
      chk($sformatf("t2_state_c%0d", i + 1), state_o, st2[i]);
      if (i < 6) tick();
    end
    chk("t2_done", done_o, 1'b1);

    // 3. abort mid-ramp at duty 4
    cfg(8'd2, 8'd8, 8'd2, 16'd3, 16'd0);
    go();
    chk("t3_duty_c1", duty_o, 8'd2);
    repeat (4) tick();
    chk("t3_duty_c5", duty_o, 8'd4);
    chk("t3_state_c5", state_o, 3'd1);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    chk("t3_state_stop", state_o, 3'd0);
    chk("t3_duty_stop", duty_o, 8'd2);
    chk("t3_busy_stop", busy_o, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_o) done_cnt++;
      tick();
    end
    chk("t3_no_done", done_cnt, 0);

    // 4. rejected start, start while busy, start+stop in idle
    cfg(8'd20, 8'd20, 8'd1, 16'd0, 16'd0);
    go();
    chk("t4_err", err_o, 1'b1);
    chk("t4_rej_state", state_o, 3'd0);
    chk("t4_rej_duty", duty_o, 8'd2);
    tick();
    chk("t4_err_clr", err_o, 1'b0);
    cfg(8'd0, 8'd8, 8'd4, 16'd0, 16'd1);
    go();
    tick();
    chk("t4_busy_duty_c2", duty_o, 8'd4);
    cfg(8'd20, 8'd20, 8'd50, 16'd7, 16'd7);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("t4_busy_start_err", err_o, 1'b0);
    chk("t4_busy_duty_c3", duty_o, 8'd8);
    chk("t4_busy_state_c3", state_o, 3'd2);
    tick(); tick(); tick();
    chk("t4_cfg_ignored_c6", duty_o, 8'd4);
    wait_idle();
    cfg(8'd0, 8'd8, 8'd4, 16'd0, 16'd1);
    start_i = 1'b1; stop_i = 1'b1;
    tick();
    start_i = 1'b0; stop_i = 1'b0;
    chk("t4_startstop_state", state_o, 3'd0);
    chk("t4_startstop_busy", busy_o, 1'b0);
    chk("t4_startstop_err", err_o, 1'b0);

    // 5. loop mode
    loop_i = 1'b1;
    cfg(8'd0, 8'd8, 8'd4, 16'd0, 16'd1);
    go();
`ifdef PWM_FADE_LOOP_EN
    done_cnt = 0; busy_drop = 0;
    for (int c = 1; c <= 16; c++) begin
      if (!busy_o) busy_drop++;
      if (done_o) done_cnt++;
      if (c == 9) begin
        chk("t5_wrap_done", done_o, 1'b1);
        chk("t5_wrap_state", state_o, 3'd1);
        chk("t5_wrap_duty", duty_o, 8'd0);
      end
      if (c == 12) loop_i = 1'b0;
      tick();
    end
    chk("t5_busy_held", busy_drop, 0);
    chk("t5_done_count", done_cnt, 1);
    chk("t5_end_state", state_o, 3'd0);
    chk("t5_end_done", done_o, 1'b1);
`else
    repeat (8) tick();
    chk("t5_oneshot_state", state_o, 3'd0);
    chk("t5_oneshot_done", done_o, 1'b1);
    tick();
    chk("t5_oneshot_stays", state_o, 3'd0);
`endif
    loop_i = 1'b0;
    tick();

    // 6. reset mid-HOLD_HI, then step 0 acts as step 1
    cfg(8'd0, 8'd8, 8'd4, 16'd0, 16'd5);
    go();
    tick(); tick(); tick();
    chk("t6_in_hold", state_o, 3'd2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_duty", duty_o, 8'd0);
    chk("t6_rst_state", state_o, 3'd0);
    chk("t6_rst_busy", busy_o, 1'b0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("t6_rst_no_done", done_o, 1'b0);
    cfg(8'd0, 8'd3, 8'd0, 16'd0, 16'd0);
    go();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t6_step0_c%0d", i + 1), duty_o, exp6[i]);
      tick();
    end
    chk("t6_step0_done", done_o, 1'b1);
    chk("t6_step0_idle", state_o, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
